scu_queued: RTL
===============

# scu_queued

Queued, rate-throttled successor to the single-shot SCU cycle model. Accepts MAC jobs through a valid/ready port into a FIFO and executes them back-to-back. Each job consumes up to `rate` of `MULTIPLIERS` multipliers per active cycle; `stall` freezes progress. Each retired job reports its tag, active compute cycles and stall cycles, so the scheduler can model throughput under power capping and back-pressure.

## Interface
- `MULTIPLIERS`, 18: physical multipliers (max MACs per cycle), ≥1
- `MULT_WIDTH`, 32: width of MAC counts and cycle counters
- `QUEUE_DEPTH`, 4: job FIFO entries, power of two, ≥2
- `TAG_WIDTH`, 4: job tag width
- `RATE_WIDTH`, 8: width of rate field; must hold `MULTIPLIERS`

Ports:
- `clk` in 1: the single clock; all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `job_valid` in 1: job offered
- `job_ready` out 1: FIFO can accept (= not full)
- `job_macs` in MULT_WIDTH: MAC count of job (0 legal)
- `job_rate` in RATE_WIDTH: multipliers allowed per cycle for this job
- `job_tag` in TAG_WIDTH: opaque job id
- `stall` in 1: suspends RUN progress this cycle
- `busy` out 1: FIFO non-empty or engine not IDLE
- `done` out 1: one-cycle retire pulse
- `done_tag` out TAG_WIDTH: tag of retired job, valid with `done`
- `cycles_used` out MULT_WIDTH: active cycles of retired job, held until next `done`
- `stall_cycles` out MULT_WIDTH: stalled RUN cycles of retired job, held until next `done`
- `queue_count` out clog2(QUEUE_DEPTH)+1: FIFO occupancy

## Operation
- Push on edge with `job_valid && job_ready`; `{macs, rate, tag}` stored. No push when full, even if a pop occurs in the same cycle.
- Effective rate is latched at LOAD: `job_rate` if 1..MULTIPLIERS; 0 or >MULTIPLIERS clamps to `MULTIPLIERS`.
- FSM states: IDLE, LOAD, RUN.
  - IDLE: if FIFO non-empty → pop head, go to LOAD.
  - LOAD: `remaining` = macs, counters cleared. Next state is RUN, or retire directly if macs = 0.
  - RUN with `stall` = 1: `remaining` unchanged; `stall_cycles` incremented.
  - RUN with `stall` = 0: `remaining -= min(remaining, rate)`; active count incremented. When the result is 0, retire.
- Retire: register `done` = 1, `done_tag`, `cycles_used` and `stall_cycles` for the next cycle. In the same edge, go to LOAD (popping the head) if the FIFO is non-empty, else IDLE.
- Active cycles per job = ceil(macs/rate); 0 for macs = 0.
- No bypass: a job pushed into an empty FIFO is visible to the FSM only from the following cycle.
- Counters saturate at 2^MULT_WIDTH−1; `remaining` arithmetic is full MULT_WIDTH with no wrap.

## Timing
- Reset values: FSM IDLE, FIFO empty, `job_ready` = 0 while `rst` high and 1 in the first cycle after, `busy` = 0, `done` = 0, `done_tag` = 0, `cycles_used` = 0, `stall_cycles` = 0, `queue_count` = 0.
- Reset mid-job flushes the FIFO and the in-flight job; no `done` for either.
- Single job, no stall, accepted at edge E0:
  - cycle after E0: IDLE
  - next cycle: LOAD
  - next N cycles: RUN
  - `done` high in the cycle after the last RUN cycle, i.e. N+3 cycles after E0.
- macs = 0: `done` high in the cycle after LOAD.
- Back-to-back: each job occupies LOAD + N (+ stall) cycles. `done` of job k coincides with LOAD of job k+1.
- `stall` is ignored in IDLE and LOAD; each stalled RUN cycle delays `done` by one.
- `busy` and `queue_count` are registered and reflect state after the current edge's push/pop.
- A push and a pop in the same cycle leave `queue_count` unchanged.

## Test plan
- Reset, then jobs macs {0, 1, 18, 19, 36, 100, 1024} at rate 18, tags 0..6:
  - `cycles_used` = {0, 1, 1, 2, 2, 6, 57}
  - tags retire in order
  - `stall_cycles` = 0
- macs = 100 at rates 1, 7, 0 (clamp), 200 (clamp) → `cycles_used` = 100, 15, 6, 6.
- Fill FIFO with 4 jobs of macs = 1800 while the engine is busy:
  - `job_ready` = 0 and `queue_count` = 4 immediately after the 4th push
  - a 5th offer is held until the first pop
  - all 5 retire, each `cycles_used` = 100.
- Job macs = 36, rate 18, `stall` high for 3 RUN cycles → `cycles_used` = 2, `stall_cycles` = 3, `done` 3 cycles later than the unstalled case.
- Back-to-back macs 18, 18, 0 → `done` pulses in consecutive 2, 2, 1 cycle intervals with no IDLE gap.
- Assert `rst` during RUN of job macs = 1024 with 2 queued → no `done`, `queue_count` = 0, `busy` = 0 next cycle; a new job then completes normally.

Source files
------------

// File: rtl/scu_queued.sv
// scu_queued: queued, rate-throttled MAC cycle model.
// Jobs enter a FIFO through a valid/ready port and run back-to-back. Each
// retired job reports its tag, active compute cycles and stalled cycles.
module scu_queued #(
    parameter int unsigned MULTIPLIERS = 18,
    parameter int unsigned MULT_WIDTH  = 32,
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter int unsigned TAG_WIDTH   = 4,
    parameter int unsigned RATE_WIDTH  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         job_valid,
    output logic                         job_ready,
    input  logic [MULT_WIDTH-1:0]        job_macs,
    input  logic [RATE_WIDTH-1:0]        job_rate,
    input  logic [TAG_WIDTH-1:0]         job_tag,
    input  logic                         stall,
    output logic                         busy,
    output logic                         done,
    output logic [TAG_WIDTH-1:0]         done_tag,
    output logic [MULT_WIDTH-1:0]        cycles_used,
    output logic [MULT_WIDTH-1:0]        stall_cycles,
    output logic [$clog2(QUEUE_DEPTH):0] queue_count
);

    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [RATE_WIDTH-1:0] MAX_RATE = RATE_WIDTH'(MULTIPLIERS);
    localparam logic [MULT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(QUEUE_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN
    } state_t;

    state_t state;

    logic [MULT_WIDTH-1:0] fifo_macs [QUEUE_DEPTH];
    logic [RATE_WIDTH-1:0] fifo_rate [QUEUE_DEPTH];
    logic [TAG_WIDTH-1:0]  fifo_tag  [QUEUE_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    logic [MULT_WIDTH-1:0] remaining;
    logic [RATE_WIDTH-1:0] cur_rate;
    logic [TAG_WIDTH-1:0]  cur_tag;
    logic [MULT_WIDTH-1:0] act_cnt;
    logic [MULT_WIDTH-1:0] stl_cnt;

    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic                  retire;
    logic                  run_last;
    logic                  engine_idle_next;
    logic [MULT_WIDTH-1:0] rate_ext;
    logic [MULT_WIDTH-1:0] step;
    logic [MULT_WIDTH-1:0] act_inc;
    logic [MULT_WIDTH-1:0] stl_inc;
    logic [RATE_WIDTH-1:0] head_rate;
    logic [RATE_WIDTH-1:0] eff_rate;
    logic [CNT_W-1:0]      count_next;

    // Handshake, retire decision, rate clamp and saturating increments.
    always_comb begin
        fifo_empty       = (queue_count == '0);
        push             = job_valid && job_ready;
        rate_ext         = MULT_WIDTH'(cur_rate);
        run_last         = (remaining <= rate_ext);
        step             = run_last ? remaining : rate_ext;
        retire           = ((state == S_LOAD) && (remaining == '0)) ||
                           ((state == S_RUN) && !stall && run_last);
        pop              = !fifo_empty && ((state == S_IDLE) || retire);
        engine_idle_next = fifo_empty && ((state == S_IDLE) || retire);
        count_next       = queue_count + CNT_W'(push) - CNT_W'(pop);
        act_inc          = (act_cnt == CNT_MAX) ? act_cnt : act_cnt + MULT_WIDTH'(1);
        stl_inc          = (stl_cnt == CNT_MAX) ? stl_cnt : stl_cnt + MULT_WIDTH'(1);
        head_rate        = fifo_rate[rd_ptr];
        eff_rate         = ((head_rate == '0) || (head_rate > MAX_RATE)) ? MAX_RATE : head_rate;
    end

    // FIFO payload storage; contents are don't-care until pointed at.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_macs[wr_ptr] <= job_macs;
            fifo_rate[wr_ptr] <= job_rate;
            fifo_tag[wr_ptr]  <= job_tag;
        end
    end

    // Engine FSM, FIFO pointers/occupancy and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            queue_count  <= '0;
            job_ready    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            done_tag     <= '0;
            cycles_used  <= '0;
            stall_cycles <= '0;
            remaining    <= '0;
            cur_rate     <= '0;
            cur_tag      <= '0;
            act_cnt      <= '0;
            stl_cnt      <= '0;
        end else begin
            done        <= 1'b0;
            queue_count <= count_next;
            job_ready   <= (count_next != FULL_CNT);
            busy        <= (count_next != '0) || !engine_idle_next;

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end

            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    act_cnt <= '0;
                    stl_cnt <= '0;
                    if (remaining != '0) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (stall) begin
                        stl_cnt <= stl_inc;
                    end else begin
                        remaining <= remaining - step;
                        act_cnt   <= act_inc;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Retiring reports the job and chains straight into the next LOAD.
            if (retire) begin
                done         <= 1'b1;
                done_tag     <= cur_tag;
                cycles_used  <= (state == S_RUN) ? act_inc : '0;
                stall_cycles <= (state == S_RUN) ? stl_cnt : '0;
                state        <= fifo_empty ? S_IDLE : S_LOAD;
            end

            // Popping captures the head job; overrides the RUN decrement.
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                remaining <= fifo_macs[rd_ptr];
                cur_rate  <= eff_rate;
                cur_tag   <= fifo_tag[rd_ptr];
                act_cnt   <= '0;
                stl_cnt   <= '0;
            end
        end
    end

endmodule
